// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_pkg
//  Description : Shared constants and helpers for the forwarding / hazard
//                unit: regfile select code, hard-wired zero register,
//                forwarding-select width derivation and stage-to-select map.
//  Revision    : 1.0  initial release
// ============================================================================
package fwd_pkg;

    // Select code meaning "take the operand from the register file".
    localparam int FW_SEL_RF = 0;

    // Register 0 always reads as zero; it is never forwarded nor tracked.
    localparam int REG_ZERO = 0;

    // Minimum select width able to encode regfile plus every forwarding stage.
    function automatic int sel_width(input int num_fw);
        int w;
        w = $clog2(num_fw + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Forwarding stage j is encoded as select j+1 (0 is reserved for regfile).
    function automatic int stage_to_sel(input int stage_idx);
        return stage_idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_scoreboard_unit_port_sel.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_port_sel
//  Description : Per-read-port forwarding priority match and hazard detect.
//                Picks the youngest in-flight writer of the port's register
//                and flags a hazard when the value cannot be supplied now.
//  Ports       : i_rd_en/i_rd_addr/i_rd_hilo  read port request
//                i_fw_wen/i_fw_waddr/i_fw_ready  forwarding stage state
//                i_busy       scoreboard bit of i_rd_addr
//                i_hilo_busy  HI/LO long op outstanding
//                o_fw_sel     0 = regfile, j+1 = stage j
//                o_hazard     this port cannot proceed this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_port_sel
    import fwd_pkg::*;
#(
    parameter int NUM_FW = 2,
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2
) (
    input  logic                     i_rd_en,
    input  logic [REG_AW-1:0]        i_rd_addr,
    input  logic                     i_rd_hilo,
    input  logic [NUM_FW-1:0]        i_fw_wen,
    input  logic [NUM_FW*REG_AW-1:0] i_fw_waddr,
    input  logic [NUM_FW-1:0]        i_fw_ready,
    input  logic                     i_busy,
    input  logic                     i_hilo_busy,
    output logic [SEL_W-1:0]         o_fw_sel,
    output logic                     o_hazard
);

    logic             w_gpr_rd;
    logic             w_hit;
    logic             w_hit_ready;
    logic [SEL_W-1:0] w_sel;

    always_comb begin
        w_gpr_rd    = i_rd_en & ~i_rd_hilo & (i_rd_addr != REG_AW'(REG_ZERO));
        w_hit       = 1'b0;
        w_hit_ready = 1'b1;
        w_sel       = SEL_W'(FW_SEL_RF);
        // Scan oldest to youngest so the lowest (youngest) matching stage
        // overwrites any older match.
        for (int j = NUM_FW - 1; j >= 0; j--) begin
            if (w_gpr_rd && i_fw_wen[j] &&
                (i_fw_waddr[j*REG_AW +: REG_AW] == i_rd_addr)) begin
                w_hit       = 1'b1;
                w_hit_ready = i_fw_ready[j];
                w_sel       = SEL_W'(stage_to_sel(j));
            end
        end
        o_fw_sel = w_sel;
        // The scoreboard is only consulted when no pipeline stage will supply
        // the value: an in-flight stage writer is younger than any long op.
        o_hazard = (w_hit & ~w_hit_ready)
                 | (w_gpr_rd & ~w_hit & i_busy)
                 | (i_rd_en & i_rd_hilo & i_hilo_busy);
    end

endmodule
`default_nettype wire

// File: rtl/fwd_scoreboard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_scoreboard_unit
//  Description : GPR/HILO forwarding and hazard unit. Per-port forwarding
//                select, long-latency busy scoreboard, HI/LO busy flag,
//                stall generation and saturating stall-cycle counter.
//  Ports       : clk, rst (sync, active high)
//                rd_*      read port requests (NUM_RD ports)
//                fw_*      forwarding stage writers (NUM_FW stages)
//                lop_*     long-latency GPR op issue / completion
//                hilo_*    HI/LO multi-cycle op issue / completion
//                sb_flush  abort all in-flight long ops
//                fw_sel, stall, stall_cnt  outputs
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_scoreboard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_RD = 4,
    parameter int NUM_FW = 2,
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*REG_AW-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_hilo,
    input  logic [NUM_FW-1:0]        fw_wen,
    input  logic [NUM_FW*REG_AW-1:0] fw_waddr,
    input  logic [NUM_FW-1:0]        fw_ready,
    input  logic                     lop_issue,
    input  logic [REG_AW-1:0]        lop_waddr,
    input  logic                     lop_done,
    input  logic [REG_AW-1:0]        lop_done_addr,
    input  logic                     hilo_issue,
    input  logic                     hilo_done,
    input  logic                     sb_flush,
    output logic [NUM_RD*SEL_W-1:0]  fw_sel,
    output logic                     stall,
    output logic [31:0]              stall_cnt
);

    localparam int NUM_REGS = 2 ** REG_AW;

    logic [NUM_REGS-1:0]     r_busy_q;
    logic [NUM_REGS-1:0]     w_busy_d;
    logic                    r_hilo_busy_q;
    logic                    w_hilo_busy_d;
    logic [31:0]             r_stall_cnt_q;
    logic [31:0]             w_stall_cnt_d;
    logic [NUM_RD*SEL_W-1:0] w_port_sel;
    logic [NUM_RD-1:0]       w_hazard;
    logic [NUM_RD-1:0]       w_busy_bit;

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_port
            assign w_busy_bit[k] = r_busy_q[rd_addr[k*REG_AW +: REG_AW]];

            fwd_port_sel #(
                .NUM_FW (NUM_FW),
                .REG_AW (REG_AW),
                .SEL_W  (SEL_W)
            ) u_port_sel (
                .i_rd_en     (rd_en[k]),
                .i_rd_addr   (rd_addr[k*REG_AW +: REG_AW]),
                .i_rd_hilo   (rd_hilo[k]),
                .i_fw_wen    (fw_wen),
                .i_fw_waddr  (fw_waddr),
                .i_fw_ready  (fw_ready),
                .i_busy      (w_busy_bit[k]),
                .i_hilo_busy (r_hilo_busy_q),
                .o_fw_sel    (w_port_sel[k*SEL_W +: SEL_W]),
                .o_hazard    (w_hazard[k])
            );
        end
    endgenerate

    // Outputs are forced quiet while reset is asserted, independent of any
    // stale scoreboard content from before reset.
    always_comb begin
        fw_sel    = rst ? '0 : w_port_sel;
        stall     = ~rst & (|w_hazard);
        stall_cnt = r_stall_cnt_q;
    end

    always_comb begin
        w_busy_d      = r_busy_q;
        w_hilo_busy_d = r_hilo_busy_q;
        if (sb_flush) begin
            // Flush aborts everything, including a same-cycle issue.
            w_busy_d      = '0;
            w_hilo_busy_d = 1'b0;
        end else begin
            // Clear before set so a same-register issue/done pair stays busy.
            if (lop_done) begin
                w_busy_d[lop_done_addr] = 1'b0;
            end
            if (lop_issue && (lop_waddr != REG_AW'(REG_ZERO))) begin
                w_busy_d[lop_waddr] = 1'b1;
            end
            if (hilo_done) begin
                w_hilo_busy_d = 1'b0;
            end
            if (hilo_issue) begin
                w_hilo_busy_d = 1'b1;
            end
        end
    end

    always_comb begin
        w_stall_cnt_d = r_stall_cnt_q;
        if (stall && (r_stall_cnt_q != 32'hFFFF_FFFF)) begin
            w_stall_cnt_d = r_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_q      <= '0;
            r_hilo_busy_q <= 1'b0;
            r_stall_cnt_q <= '0;
        end else begin
            r_busy_q      <= w_busy_d;
            r_hilo_busy_q <= w_hilo_busy_d;
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_scoreboard_unit
//  Description : Self-checking bench for fwd_scoreboard_unit. Directed
//                scenarios followed by randomized traffic, all compared
//                against a behavioural model of the forwarding rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fwd_scoreboard_unit;

    localparam int NUM_RD = 4;
    localparam int NUM_FW = 2;
    localparam int REG_AW = 5;
    localparam int SEL_W  = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*REG_AW-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_hilo;
    logic [NUM_FW-1:0]        fw_wen;
    logic [NUM_FW*REG_AW-1:0] fw_waddr;
    logic [NUM_FW-1:0]        fw_ready;
    logic                     lop_issue;
    logic [REG_AW-1:0]        lop_waddr;
    logic                     lop_done;
    logic [REG_AW-1:0]        lop_done_addr;
    logic                     hilo_issue;
    logic                     hilo_done;
    logic                     sb_flush;
    logic [NUM_RD*SEL_W-1:0]  fw_sel;
    logic                     stall;
    logic [31:0]              stall_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Behavioural model state
    bit      m_busy [32];
    bit      m_hilo;
    longint  m_cnt;

    // Values observed at the last step's comparison point
    logic [NUM_RD*SEL_W-1:0] s_sel;
    logic                    s_stall;

    fwd_scoreboard_unit #(
        .NUM_RD (NUM_RD),
        .NUM_FW (NUM_FW),
        .REG_AW (REG_AW),
        .SEL_W  (SEL_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_hilo       (rd_hilo),
        .fw_wen        (fw_wen),
        .fw_waddr      (fw_waddr),
        .fw_ready      (fw_ready),
        .lop_issue     (lop_issue),
        .lop_waddr     (lop_waddr),
        .lop_done      (lop_done),
        .lop_done_addr (lop_done_addr),
        .hilo_issue    (hilo_issue),
        .hilo_done     (hilo_done),
        .sb_flush      (sb_flush),
        .fw_sel        (fw_sel),
        .stall         (stall),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Expected combinational outputs from the forwarding rules.
    function automatic void mdl_comb(output logic [NUM_RD*SEL_W-1:0] esel,
                                     output logic estall);
        esel   = '0;
        estall = 1'b0;
        if (!rst) begin
            for (int k = 0; k < NUM_RD; k++) begin
                int          src;
                bit          rdy;
                bit          gpr;
                logic [4:0]  a;
                a   = rd_addr[k*REG_AW +: REG_AW];
                gpr = rd_en[k] && !rd_hilo[k] && (a != 0);
                src = -1;
                rdy = 1'b1;
                if (gpr) begin
                    for (int j = 0; j < NUM_FW; j++) begin
                        if (src < 0 && fw_wen[j] && fw_waddr[j*REG_AW +: REG_AW] == a) begin
                            src = j;
                            rdy = fw_ready[j];
                        end
                    end
                end
                if (src >= 0) begin
                    esel[k*SEL_W +: SEL_W] = 2'(src + 1);
                    if (!rdy) estall = 1'b1;
                end else if (gpr && m_busy[a]) begin
                    estall = 1'b1;
                end
                if (rd_en[k] && rd_hilo[k] && m_hilo) estall = 1'b1;
            end
        end
    endfunction

    // Advance model state across one clock edge.
    function automatic void mdl_edge(input logic was_stall);
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_hilo = 1'b0;
            m_cnt  = 0;
        end else begin
            if (was_stall && m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt++;
            if (sb_flush) begin
                foreach (m_busy[i]) m_busy[i] = 1'b0;
                m_hilo = 1'b0;
            end else begin
                bit nb [32];
                bit nh;
                nb = m_busy;
                nh = m_hilo;
                if (lop_done)  nb[lop_done_addr] = 1'b0;
                if (hilo_done) nh = 1'b0;
                if (lop_issue && lop_waddr != 0) nb[lop_waddr] = 1'b1;
                if (hilo_issue) nh = 1'b1;
                m_busy = nb;
                m_hilo = nh;
            end
        end
    endfunction

    // One cycle: compare combinational outputs mid-cycle, clock, compare counter.
    task automatic step();
        logic [NUM_RD*SEL_W-1:0] esel;
        logic                    estall;
        @(negedge clk);
        mdl_comb(esel, estall);
        s_sel   = fw_sel;
        s_stall = stall;
        for (int k = 0; k < NUM_RD; k++)
            chk($sformatf("fw_sel%0d", k), 32'(fw_sel[k*SEL_W +: SEL_W]),
                32'(esel[k*SEL_W +: SEL_W]));
        chk("stall", 32'(stall), 32'(estall));
        @(posedge clk);
        #1;
        mdl_edge(estall);
        cyc++;
        chk("stall_cnt", stall_cnt, m_cnt[31:0]);
    endtask

    task automatic clr();
        rd_en = '0; rd_addr = '0; rd_hilo = '0;
        fw_wen = '0; fw_waddr = '0; fw_ready = '1;
        lop_issue = 1'b0; lop_waddr = '0; lop_done = 1'b0; lop_done_addr = '0;
        hilo_issue = 1'b0; hilo_done = 1'b0; sb_flush = 1'b0;
    endtask

    task automatic set_rd(input int k, input logic [4:0] a, input logic hl);
        rd_en[k] = 1'b1;
        rd_addr[k*REG_AW +: REG_AW] = a;
        rd_hilo[k] = hl;
    endtask

    task automatic set_fw(input int j, input logic [4:0] a, input logic rdy);
        fw_wen[j] = 1'b1;
        fw_waddr[j*REG_AW +: REG_AW] = a;
        fw_ready[j] = rdy;
    endtask

    initial begin
        longint base;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_hilo = 1'b0;
        m_cnt  = 0;
        clr();
        rst = 1'b1;
        step();
        step();
        chk("reset_cnt", stall_cnt, 32'd0);
        rst = 1'b0;

        // Youngest of two matching ready stages wins.
        clr(); set_rd(0, 5'd8, 1'b0); set_fw(0, 5'd8, 1'b1); set_fw(1, 5'd8, 1'b1);
        step();
        chk("t1_sel0", 32'(s_sel[1:0]), 32'd1);
        chk("t1_stall", 32'(s_stall), 32'd0);

        // Load in flight in stage 0, then becomes ready.
        clr(); set_rd(1, 5'd9, 1'b0); set_fw(0, 5'd9, 1'b0);
        step();
        chk("t2_stall_load", 32'(s_stall), 32'd1);
        fw_ready[0] = 1'b1;
        step();
        chk("t2_stall_rdy", 32'(s_stall), 32'd0);
        chk("t2_sel1", 32'(s_sel[3:2]), 32'd1);

        // Long op to r5: 10 stalled reads, done on the 10th, free on the 11th.
        clr(); lop_issue = 1'b1; lop_waddr = 5'd5;
        step();
        base = m_cnt;
        for (int i = 1; i <= 11; i++) begin
            clr(); set_rd(2, 5'd5, 1'b0);
            if (i == 10) begin lop_done = 1'b1; lop_done_addr = 5'd5; end
            step();
            chk($sformatf("t3_stall_c%0d", i), 32'(s_stall), (i <= 10) ? 32'd1 : 32'd0);
        end
        chk("t3_cnt", stall_cnt, 32'(base + 10));

        // Same-cycle issue and done to r7: set wins.
        clr(); lop_issue = 1'b1; lop_waddr = 5'd7; lop_done = 1'b1; lop_done_addr = 5'd7;
        step();
        clr(); set_rd(3, 5'd7, 1'b0);
        step();
        chk("t4_stall", 32'(s_stall), 32'd1);
        clr(); lop_done = 1'b1; lop_done_addr = 5'd7;
        step();

        // Flush releases r3 and HI/LO; the flush cycle itself still stalls.
        clr(); lop_issue = 1'b1; lop_waddr = 5'd3; hilo_issue = 1'b1;
        step();
        clr(); set_rd(0, 5'd3, 1'b0); set_rd(1, 5'd0, 1'b1); sb_flush = 1'b1;
        lop_issue = 1'b1; lop_waddr = 5'd3; hilo_issue = 1'b1;
        step();
        chk("t5_flush_stall", 32'(s_stall), 32'd1);
        clr(); set_rd(0, 5'd3, 1'b0); set_rd(1, 5'd0, 1'b1);
        step();
        chk("t5_after_flush", 32'(s_stall), 32'd0);

        // r0 is never forwarded or stalled on.
        clr(); set_rd(0, 5'd0, 1'b0); set_fw(0, 5'd0, 1'b0);
        step();
        chk("t6_r0_sel", 32'(s_sel[1:0]), 32'd0);
        chk("t6_r0_stall", 32'(s_stall), 32'd0);
        // Reset in the middle of a stall.
        clr(); lop_issue = 1'b1; lop_waddr = 5'd4;
        step();
        clr(); set_rd(0, 5'd4, 1'b0);
        step();
        chk("t6_pre_rst_stall", 32'(s_stall), 32'd1);
        rst = 1'b1;
        step();
        chk("t6_rst_stall", 32'(s_stall), 32'd0);
        chk("t6_rst_cnt", stall_cnt, 32'd0);
        rst = 1'b0;

        // Randomized traffic over a small register set to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            clr();
            rst = ($urandom_range(0, 99) < 2);
            for (int k = 0; k < NUM_RD; k++) begin
                rd_en[k] = $urandom_range(0, 3) != 0;
                rd_addr[k*REG_AW +: REG_AW] = 5'($urandom_range(0, 7));
                rd_hilo[k] = $urandom_range(0, 7) == 0;
            end
            for (int j = 0; j < NUM_FW; j++) begin
                fw_wen[j] = $urandom_range(0, 1);
                fw_waddr[j*REG_AW +: REG_AW] = 5'($urandom_range(0, 7));
                fw_ready[j] = $urandom_range(0, 3) != 0;
            end
            lop_issue     = $urandom_range(0, 3) == 0;
            lop_waddr     = 5'($urandom_range(0, 7));
            lop_done      = $urandom_range(0, 2) == 0;
            lop_done_addr = 5'($urandom_range(0, 7));
            hilo_issue    = $urandom_range(0, 7) == 0;
            hilo_done     = $urandom_range(0, 3) == 0;
            sb_flush      = $urandom_range(0, 19) == 0;
            step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
